// File: rtl/mem_dump_tx_pkg.sv
// Shared types and constants for the memory readback engine.
// Holds the FSM state encoding and the byte-selection helper used by the top.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam int FRAME_BITS     = 10;
    localparam int BYTES_PER_WORD = 4;

    // Pick byte idx of a word, byte 0 being the least significant.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = w[7:0];
            2'd1:    word_byte = w[15:8];
            2'd2:    word_byte = w[23:16];
            default: word_byte = w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_dump_tx_if.sv
// Command and RAM-port bundle of the memory readback engine.
// The slave modport is the engine's view; master is the host/RAM side.
interface mem_dump_tx_if #(
    parameter int ADR_W = 14
);
    logic             start;
    logic [ADR_W-1:0] start_adr;
    logic [ADR_W:0]   word_cnt;
    logic             mem_ren;
    logic [ADR_W-1:0] mem_adr;
    logic [31:0]      mem_dat;
    logic             busy;
    logic             done;

    modport master (
        output start, start_adr, word_cnt, mem_dat,
        input  mem_ren, mem_adr, busy, done
    );

    modport slave (
        input  start, start_adr, word_cnt, mem_dat,
        output mem_ren, mem_adr, busy, done
    );
endinterface

// File: rtl/mem_dump_tx_uart.sv
// 8N1 UART byte transmitter with its own baud and bit counters.
// ready is also high in the final stop-bit cycle so frames can be chained gap-free.
module uart_tx_byte
    import mem_dump_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  STOP_IDX  = 4'(FRAME_BITS - 1);

    logic        active_r;
    logic [15:0] baud_cnt_r;
    logic [3:0]  bit_cnt_r;
    logic [8:0]  shift_r;
    logic        tx_r;
    logic        bit_end_s;
    logic        ready_s;

    // Bit boundary detection and readiness for the next byte.
    always_comb begin
        bit_end_s = active_r && (baud_cnt_r == BAUD_LAST);
        ready_s   = !active_r || (bit_end_s && (bit_cnt_r == STOP_IDX));
    end

    // Frame sequencer: start bit on accept, then data LSB first, then stop bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r   <= 1'b0;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 9'h1FF;
            tx_r       <= 1'b1;
        end else if (send && ready_s) begin
            active_r   <= 1'b1;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {1'b1, data};
            tx_r       <= 1'b0;
        end else if (bit_end_s) begin
            baud_cnt_r <= 16'd0;
            if (bit_cnt_r == STOP_IDX) begin
                active_r <= 1'b0;
                tx_r     <= 1'b1;
            end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
                tx_r      <= shift_r[0];
                shift_r   <= {1'b1, shift_r[8:1]};
            end
        end else if (active_r) begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
        end
    end

    assign tx    = tx_r;
    assign ready = ready_s;
endmodule

// File: rtl/mem_dump_tx.sv
// Memory readback engine: reads a block of RAM words and streams them on a UART,
// four bytes per word, least significant byte first.
module mem_dump_tx
    import mem_dump_pkg::*;
#(
    parameter int BAUD_DIV = 868,
    parameter int ADR_W    = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_dump_tx_if.slave    bus,
    output logic            tx
);
    localparam logic [ADR_W-1:0] ADR_ONE = {{(ADR_W-1){1'b0}}, 1'b1};
    localparam logic [ADR_W:0]   CNT_ONE = {{ADR_W{1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt;
    logic [31:0]      word_r;
    logic [1:0]       byte_idx_r;
    logic [ADR_W-1:0] adr_r;
    logic [ADR_W:0]   rem_r;
    logic             mem_ren_r;
    logic             busy_r;
    logic             done_r;
    logic [ADR_W-1:0] rd_adr_s;
    logic             last_byte_s;
    logic             uart_send_s;
    logic [7:0]       uart_data_s;
    logic             uart_ready_s;

    // Next-state and UART feed. Byte 0 comes straight from the RAM port so the
    // start bit begins the cycle after WAIT.
    always_comb begin
        state_nxt   = state_r;
        uart_send_s = 1'b0;
        uart_data_s = 8'h00;
        last_byte_s = (byte_idx_r == 2'd3);
        if (state_r == S_IDLE) begin
            rd_adr_s = bus.start_adr;
        end else begin
            rd_adr_s = adr_r + ADR_ONE;
        end
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.word_cnt != '0) ? S_READ : S_FIN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: begin
                state_nxt   = S_SEND;
                uart_send_s = 1'b1;
                uart_data_s = bus.mem_dat[7:0];
            end
            S_SEND: begin
                if (uart_ready_s) begin
                    if (last_byte_s) begin
                        state_nxt = (rem_r == CNT_ONE) ? S_FIN : S_READ;
                    end else begin
                        uart_send_s = 1'b1;
                        uart_data_s = word_byte(word_r, byte_idx_r + 2'd1);
                    end
                end else begin
                    state_nxt = S_SEND;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            word_r     <= 32'd0;
            byte_idx_r <= 2'd0;
            adr_r      <= '0;
            rem_r      <= '0;
            mem_ren_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            mem_ren_r <= (state_nxt == S_READ);
            busy_r    <= (state_nxt != S_IDLE);
            done_r    <= (state_nxt == S_FIN);
            // Address advances (and wraps) only when a read is issued.
            if (state_nxt == S_READ) begin
                adr_r <= rd_adr_s;
            end
            if ((state_r == S_IDLE) && bus.start) begin
                rem_r <= bus.word_cnt;
            end else if ((state_r == S_SEND) && uart_ready_s && last_byte_s) begin
                rem_r <= rem_r - CNT_ONE;
            end
            if (state_r == S_WAIT) begin
                word_r     <= bus.mem_dat;
                byte_idx_r <= 2'd0;
            end else if ((state_r == S_SEND) && uart_ready_s && !last_byte_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
            end
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .send  (uart_send_s),
        .data  (uart_data_s),
        .tx    (tx),
        .ready (uart_ready_s)
    );

    assign bus.mem_ren = mem_ren_r;
    assign bus.mem_adr = adr_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench for mem_dump_tx: table-driven dumps with a byte/read scoreboard,
// plus hand-written reset-abort and full-rate bit-timing sequences.
module tb_mem_dump_tx;
    localparam int D  = 4;
    localparam int P  = 2 + 40 * D;
    localparam int D2 = 868;
    localparam int P2 = 2 + 40 * D2;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } byte_exp_t;

    typedef struct {
        int         cyc;
        logic [13:0] adr;
    } ren_exp_t;

    typedef struct {
        logic [13:0] adr;
        logic [14:0] cnt;
        int          mid;
        int          done_cyc;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic tx;
    logic tx2;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;
    int base   = 0;
    int gen    = 0;

    byte_exp_t byte_q[$];
    ren_exp_t  ren_q[$];
    vec_t      vecs[5];

    mem_dump_tx_if #(.ADR_W(14)) bus ();
    mem_dump_tx_if #(.ADR_W(14)) bus2 ();

    mem_dump_tx #(.BAUD_DIV(D), .ADR_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .tx(tx)
    );
    mem_dump_tx #(.BAUD_DIV(D2), .ADR_W(14)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .tx(tx2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [31:0] ram_val(input logic [13:0] a);
        if (a == 14'd5) return 32'h12345678;
        else return {2'b10, a, 2'b01, a};
    endfunction

    // RAM models: data valid the cycle after the read strobe.
    always @(posedge clk) if (bus.mem_ren === 1'b1) bus.mem_dat <= ram_val(bus.mem_adr);
    always @(posedge clk) if (bus2.mem_ren === 1'b1) bus2.mem_dat <= ram_val(bus2.mem_adr);

    function automatic int cyc();
        return edge_n - base + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected tx level at cycle c of a one-word dump of word w at baud divisor d.
    function automatic logic exp_tx(input int c, input int d, input logic [31:0] w);
        int off, fr, bi;
        logic [31:0] sh;
        if (c < 3) return 1'b1;
        off = c - 3;
        if (off >= 40 * d) return 1'b1;
        fr = off / (10 * d);
        bi = (off % (10 * d)) / d;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        sh = w >> (8 * fr);
        return sh[bi - 1];
    endfunction

    // UART decoder on the D=4 instance; pops the byte scoreboard per frame.
    int         dec_s;
    int         dec_g;
    logic [7:0] dec_b;
    logic       dec_start_ok;
    logic       dec_stop_ok;
    byte_exp_t  dec_e;
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            dec_s = cyc();
            dec_g = gen;
            repeat (D / 2) @(negedge clk);
            dec_start_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (D) @(negedge clk);
                dec_b[i] = tx;
            end
            repeat (D) @(negedge clk);
            dec_stop_ok = (tx === 1'b1);
            if (dec_g == gen) begin
                if (byte_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got byte %0h, expected no frame", dec_b);
                end else begin
                    dec_e = byte_q.pop_front();
                    check("tx_byte", 64'(dec_b), 64'(dec_e.data));
                    check("frame_start_cycle", 64'(dec_s), 64'(dec_e.cyc));
                    check("framing", {62'd0, dec_start_ok, dec_stop_ok}, 64'd3);
                end
            end
            repeat (D - D / 2 - 1) @(negedge clk);
        end
    end

    // Read-strobe monitor on the D=4 instance.
    ren_exp_t ren_e;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.mem_ren === 1'b1) begin
            if (ren_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_mem_ren: got adr %0h at cycle %0d, expected none", bus.mem_adr, cyc());
            end else begin
                ren_e = ren_q.pop_front();
                check("mem_ren_cycle", 64'(cyc()), 64'(ren_e.cyc));
                check("mem_adr", 64'(bus.mem_adr), 64'(ren_e.adr));
            end
        end
    end

    task automatic push_expect(input logic [13:0] adr, input logic [14:0] cnt);
        for (int k = 0; k < int'(cnt); k++) begin
            logic [13:0] a;
            logic [31:0] w;
            a = adr + 14'(k);
            w = ram_val(a);
            ren_q.push_back('{cyc: 1 + k * P, adr: a});
            for (int j = 0; j < 4; j++) begin
                byte_q.push_back('{data: w[8*j +: 8], cyc: 3 + k * P + 10 * D * j});
            end
        end
    endtask

    task automatic issue_start(input logic [13:0] adr, input logic [14:0] cnt);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.start_adr = adr;
        bus.word_cnt  = cnt;
        base          = edge_n + 1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.start_adr = adr ^ 14'h2AAA;
        bus.word_cnt  = cnt + 15'd5;
    endtask

    task automatic run_dump(input logic [13:0] adr, input logic [14:0] cnt, input int mid,
                            input int done_exp, input string name);
        int busy_err;
        int done_at;
        busy_err = 0;
        done_at  = -1;
        push_expect(adr, cnt);
        issue_start(adr, cnt);
        for (int t = 0; t < 4000; t++) begin
            bus.start = (cyc() == mid);
            if (bus.start) bus.start_adr = adr + 14'd1000;
            if (bus.done === 1'b1) begin
                done_at = cyc();
                break;
            end
            if (bus.busy !== 1'b1) busy_err++;
            @(negedge clk);
        end
        check({name, " done_cycle"}, 64'(done_at), 64'(done_exp));
        check({name, " busy_window"}, 64'(busy_err), 64'd0);
        check({name, " busy_at_done"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check({name, " busy_after_done"}, 64'(bus.busy), 64'd0);
        check({name, " done_width"}, 64'(bus.done), 64'd0);
        check({name, " bytes_outstanding"}, 64'(byte_q.size()), 64'd0);
        check({name, " reads_outstanding"}, 64'(ren_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int ren_cnt;
        int ren_err;
        int done_at;
        int done_seen;
        logic [31:0] w;

        vecs[0] = '{adr: 14'd5,     cnt: 15'd1, mid: 0,   done_cyc: 163, name: "single_word"};
        vecs[1] = '{adr: 14'd16383, cnt: 15'd3, mid: 0,   done_cyc: 487, name: "wrap"};
        vecs[2] = '{adr: 14'd77,    cnt: 15'd0, mid: 0,   done_cyc: 1,   name: "zero_count"};
        vecs[3] = '{adr: 14'd200,   cnt: 15'd2, mid: 100, done_cyc: 325, name: "start_while_busy"};
        vecs[4] = '{adr: 14'd9,     cnt: 15'd1, mid: 163, done_cyc: 163, name: "start_in_fin"};

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.start_adr  = 14'd0;
        bus.word_cnt   = 15'd0;
        bus2.start     = 1'b0;
        bus2.start_adr = 14'd0;
        bus2.word_cnt  = 15'd0;
        repeat (3) @(negedge clk);
        check("reset tx", 64'(tx), 64'd1);
        check("reset mem_ren", 64'(bus.mem_ren), 64'd0);
        check("reset mem_adr", 64'(bus.mem_adr), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_dump(vecs[v].adr, vecs[v].cnt, vecs[v].mid, vecs[v].done_cyc, vecs[v].name);
            repeat (3) @(negedge clk);
        end

        // Reset during data bits of byte 2 (cycles 87..118) of a two-word dump.
        push_expect(14'd40, 15'd2);
        issue_start(14'd40, 15'd2);
        for (int t = 0; t < 200 && cyc() < 95; t++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort tx", 64'(tx), 64'd1);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        byte_q.delete();
        ren_q.delete();
        gen++;
        rst_n = 1'b1;
        done_seen = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
        end
        check("abort no_done", 64'(done_seen), 64'd0);
        run_dump(14'd40, 15'd2, 0, 325, "after_reset");

        // Full-rate bit timing on the second instance, checked cycle by cycle.
        w = ram_val(14'd3);
        errs = 0;
        ren_cnt = 0;
        ren_err = 0;
        done_at = -1;
        @(negedge clk);
        bus2.start     = 1'b1;
        bus2.start_adr = 14'd3;
        bus2.word_cnt  = 15'd1;
        base           = edge_n + 1;
        @(negedge clk);
        bus2.start     = 1'b0;
        bus2.start_adr = 14'd100;
        for (int t = 0; t < P2 + 5; t++) begin
            if (tx2 !== exp_tx(cyc(), D2, w)) begin
                if (errs == 0) $display("FAIL bit_timing: cycle %0d got tx %b expected %b", cyc(), tx2, exp_tx(cyc(), D2, w));
                errs++;
            end
            if (bus2.mem_ren === 1'b1) begin
                ren_cnt++;
                if (cyc() != 1 || bus2.mem_adr !== 14'd3) ren_err++;
            end
            if (bus2.done === 1'b1) done_at = cyc();
            @(negedge clk);
        end
        check("baud868 tx_waveform_errors", 64'(errs), 64'd0);
        check("baud868 mem_ren_count", 64'(ren_cnt), 64'd1);
        check("baud868 mem_ren_cycle_adr", 64'(ren_err), 64'd0);
        check("baud868 done_cycle", 64'(done_at), 64'(1 + P2));
        check("baud868 busy_after", 64'(bus2.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
